// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between two hart IO ports (A and B). Each port
// writes characters into its own small FIFO. A round-robin arbiter drains the
// two FIFOs into a registered valid/ready output stage that feeds the UART.
// The per-port full flags are the "UART busy" poll bits seen by each hart.
//
// Ports:
//   i_clk      system clock
//   i_rst      synchronous active-high reset
//   i_a_valid  port A write strobe
//   i_a_data   port A character
//   o_a_full   port A FIFO holds DEPTH entries
//   o_a_drop   one-cycle pulse: a port A write was discarded
//   i_b_valid  port B write strobe
//   i_b_data   port B character
//   o_b_full   port B FIFO holds DEPTH entries
//   o_b_drop   one-cycle pulse: a port B write was discarded
//   o_valid    character offered to the UART
//   o_data     character to the UART
//   i_ready    UART ready (accepts o_data when o_valid is also high)
//   o_idle     both FIFOs empty and nothing offered
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Per-port byte FIFO. Full and empty come from an occupancy counter so the
// pointers may wrap freely. A write while full is discarded and reported by a
// registered one-cycle drop pulse. A write while full is rejected even when a
// pop happens on the same edge.
//
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   wr_valid  write strobe
//   wr_data   write character
//   pop       remove the head entry (ignored when empty)
//   rd_data   head entry (valid when not empty)
//   full      FIFO holds DEPTH entries
//   empty     FIFO holds no entries
//   drop      one-cycle pulse after a discarded write
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic          drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          drop_r;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  // Occupancy flags and accepted push/pop qualifiers from pre-edge state.
  always_comb begin
    full_s  = (count_r == CNT_FULL);
    empty_s = (count_r == CNT_ZERO);
    push_s  = wr_valid & ~full_s;
    pop_s   = pop & ~empty_s;
  end

  // Character storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Occupancy counter; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_ZERO;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Drop pulse: high for exactly the cycle after a rejected write.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r <= 1'b0;
    end else begin
      drop_r <= wr_valid & full_s;
    end
  end

  // Output drive.
  always_comb begin
    rd_data = mem_r[rd_ptr_r];
    full    = full_s;
    empty   = empty_s;
    drop    = drop_r;
  end

endmodule

// ---------------------------------------------------------------------------
// uart_tx_arbiter (top)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_valid,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_full,
  output logic          o_a_drop,
  input  logic          i_b_valid,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_full,
  output logic          o_b_drop,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_ready,
  output logic          o_idle
);

  logic [DW-1:0] a_rd_s;
  logic [DW-1:0] b_rd_s;
  logic          a_full_s;
  logic          b_full_s;
  logic          a_empty_s;
  logic          b_empty_s;
  logic          a_drop_s;
  logic          b_drop_s;

  logic          xfer_s;
  logic          load_s;
  logic          pop_a_s;
  logic          pop_b_s;

  logic          valid_r;
  logic [DW-1:0] data_r;
  // 1: port B was granted last, so A wins the next contention.
  logic          last_grant_b_r;

  uart_tx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_valid (i_a_valid),
    .wr_data  (i_a_data),
    .pop      (pop_a_s),
    .rd_data  (a_rd_s),
    .full     (a_full_s),
    .empty    (a_empty_s),
    .drop     (a_drop_s)
  );

  uart_tx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk      (i_clk),
    .rst      (i_rst),
    .wr_valid (i_b_valid),
    .wr_data  (i_b_data),
    .pop      (pop_b_s),
    .rd_data  (b_rd_s),
    .full     (b_full_s),
    .empty    (b_empty_s),
    .drop     (b_drop_s)
  );

  // Round-robin grant: the output stage reloads when empty or on a transfer.
  always_comb begin
    xfer_s  = valid_r & i_ready;
    load_s  = ~valid_r | xfer_s;
    pop_a_s = 1'b0;
    pop_b_s = 1'b0;
    if (load_s) begin
      if (~a_empty_s & ~b_empty_s) begin
        if (last_grant_b_r) begin
          pop_a_s = 1'b1;
        end else begin
          pop_b_s = 1'b1;
        end
      end else if (~a_empty_s) begin
        pop_a_s = 1'b1;
      end else if (~b_empty_s) begin
        pop_b_s = 1'b1;
      end else begin
        pop_a_s = 1'b0;
        pop_b_s = 1'b0;
      end
    end else begin
      pop_a_s = 1'b0;
      pop_b_s = 1'b0;
    end
  end

  // Output stage: holds the offered character stable until the UART takes it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_r        <= 1'b0;
      data_r         <= {DW{1'b0}};
      last_grant_b_r <= 1'b1;
    end else if (load_s) begin
      if (pop_a_s) begin
        valid_r        <= 1'b1;
        data_r         <= a_rd_s;
        last_grant_b_r <= 1'b0;
      end else if (pop_b_s) begin
        valid_r        <= 1'b1;
        data_r         <= b_rd_s;
        last_grant_b_r <= 1'b1;
      end else begin
        valid_r <= 1'b0;
      end
    end
  end

  // Output drive; full and idle are decoded from current state.
  always_comb begin
    o_valid  = valid_r;
    o_data   = data_r;
    o_a_full = a_full_s;
    o_b_full = b_full_s;
    o_a_drop = a_drop_s;
    o_b_drop = b_drop_s;
    o_idle   = a_empty_s & b_empty_s & ~valid_r;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic [DW-1:0] a_data = 8'h00;
  logic          b_valid = 1'b0;
  logic [DW-1:0] b_data = 8'h00;
  logic          ready = 1'b0;
  logic          o_a_full, o_a_drop, o_b_full, o_b_drop, o_valid, o_idle;
  logic [DW-1:0] o_data;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_model = 1'b0;

  // Reference model: two queues plus the offered character.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_last_b = 1'b1;
  logic       m_drop_a = 1'b0;
  logic       m_drop_b = 1'b0;

  logic [7:0] got[$];

  uart_tx_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_a_valid (a_valid),
    .i_a_data  (a_data),
    .o_a_full  (o_a_full),
    .o_a_drop  (o_a_drop),
    .i_b_valid (b_valid),
    .i_b_data  (b_data),
    .o_b_full  (o_b_full),
    .o_b_drop  (o_b_drop),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .i_ready   (ready),
    .o_idle    (o_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       efa;
    logic       efb;
    logic       eda;
    logic       edb;
    logic       eidle;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the specification's rules, applied to the model state.
  task automatic model_step();
    bit na, nb, xfer, load, ga, gb;
    if (rst) begin
      qa.delete();
      qb.delete();
      m_valid  = 1'b0;
      m_data   = 8'h00;
      m_last_b = 1'b1;
      m_drop_a = 1'b0;
      m_drop_b = 1'b0;
      return;
    end
    na   = (qa.size() != 0);
    nb   = (qb.size() != 0);
    xfer = m_valid && ready;
    load = !m_valid || xfer;
    ga = 1'b0;
    gb = 1'b0;
    if (load) begin
      if (na && nb) begin
        if (m_last_b) ga = 1'b1;
        else gb = 1'b1;
      end else if (na) ga = 1'b1;
      else if (nb) gb = 1'b1;
    end
    m_drop_a = a_valid && (qa.size() == DEPTH);
    m_drop_b = b_valid && (qb.size() == DEPTH);
    if (ga) begin
      m_data = qa.pop_front();
      m_valid = 1'b1;
      m_last_b = 1'b0;
    end else if (gb) begin
      m_data = qb.pop_front();
      m_valid = 1'b1;
      m_last_b = 1'b1;
    end else if (load) begin
      m_valid = 1'b0;
    end
    if (a_valid && !m_drop_a) qa.push_back(a_data);
    if (b_valid && !m_drop_b) qb.push_back(b_data);
  endtask

  function automatic logic [31:0] dut_vec();
    return {19'd0, o_valid, o_data, o_a_full, o_b_full, o_a_drop, o_b_drop, o_idle};
  endfunction

  function automatic logic [31:0] model_vec();
    logic fa, fb, idle;
    fa   = (qa.size() == DEPTH);
    fb   = (qb.size() == DEPTH);
    idle = (qa.size() == 0) && (qb.size() == 0) && !m_valid;
    return {19'd0, m_valid, m_data, fa, fb, m_drop_a, m_drop_b, idle};
  endfunction

  task automatic tick();
    if (o_valid && ready && !rst) got.push_back(o_data);
    model_step();
    @(posedge clk);
    #1;
    if (chk_model) check("model", dut_vec(), model_vec());
  endtask

  task automatic drive(input logic r, input logic av, input logic [7:0] ad,
                       input logic bv, input logic [7:0] bd, input logic rdy);
    rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; ready = rdy;
  endtask

  initial begin
    int unsigned pa, pb, pr;
    logic [7:0] exp_b;

    //            rst   av    ad     bv    bd     rdy   ev    ed     efa   efb   eda   edb   idle
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'h41, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h13, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'h14, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'h15, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Table-driven vectors: reset, single write latency, contention, fill/drop.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].rdy);
      tick();
      check($sformatf("vec%0d", i), dut_vec(),
            {19'd0, vecs[i].ev, vecs[i].ed, vecs[i].efa, vecs[i].efb,
             vecs[i].eda, vecs[i].edb, vecs[i].eidle});
    end

    chk_model = 1'b1;

    // Interleave: A 30..33 and B 40..43 written together, ready held high.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    got.delete();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'(8'h30 + i), 1'b1, 8'(8'h40 + i), 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (15) tick();
    check("ilv_len", got.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i % 2 == 0) ? 8'(8'h30 + i / 2) : 8'(8'h40 + i / 2);
      if (i < got.size()) check($sformatf("ilv_byte%0d", i), {24'd0, got[i]}, {24'd0, exp_b});
    end
    check("ilv_idle", {31'd0, o_idle}, 32'd1);

    // Fill A with ready low, drop the sixth write, hold 20 cycles, then drain.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    got.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 8'h00, 1'b0);
      tick();
    end
    check("fill_full", {31'd0, o_a_full}, 32'd1);
    drive(1'b0, 1'b1, 8'h15, 1'b0, 8'h00, 1'b0);
    tick();
    check("drop_pulse", {31'd0, o_a_drop}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    check("drop_clear", {31'd0, o_a_drop}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_data", {23'd0, o_valid, o_data}, {23'd0, 1'b1, 8'h10});
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (10) tick();
    check("drain_len", got.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) check($sformatf("drain_byte%0d", i), {24'd0, got[i]}, 32'(8'h10 + i));
    end

    // Reset while one character is offered and three are queued.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b0);
      tick();
    end
    check("pre_rst_valid", {31'd0, o_valid}, 32'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    check("rst_state", {30'd0, o_valid, o_idle}, 32'd1);
    got.delete();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (10) tick();
    check("rst_no_emit", got.size(), 32'd0);

    // Randomized traffic against the model, with varying load and backpressure.
    for (int seg = 0; seg < 8; seg++) begin
      pa = $urandom_range(0, 100);
      pb = $urandom_range(0, 100);
      pr = $urandom_range(5, 100);
      for (int c = 0; c < 400; c++) begin
        drive(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 99) < pa), 8'($urandom),
              ($urandom_range(0, 99) < pb), 8'($urandom),
              ($urandom_range(0, 99) < pr));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
